// File: rtl/step_arb_pkg.sv
// Shared types for the step arbiter: sequencer states, phase encodings and the phase step rule.
package step_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b10;
  localparam logic [1:0] PH3 = 2'b11;

  // The high bit toggles when k is set and the low bit always toggles.
  // With k = q[0] this counts PH0->PH1->PH2->PH3->PH0.
  function automatic logic [1:0] ph_next(input logic [1:0] q, input logic k);
    return {q[1] ^ k, ~q[0]};
  endfunction

endpackage

// File: rtl/phase_seq.sv
// 2-bit k-driven phase sequencer. It advances one step per enabled cycle and holds otherwise.
module phase_seq
  import step_arb_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       k,
  output logic [1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= PH0;
    else if (en) q <= ph_next(q, k);
  end

endmodule

// File: rtl/step_arbiter.sv
// Two-requester job arbiter that steps a shared phase sequencer once per RUN cycle.
// Define STEP_ARB_RR_EN for round-robin tie breaking; the default is fixed priority to requester 0.
module step_arbiter
  import step_arb_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [1:0]    req,
  input  logic [CW-1:0] cnt0,
  input  logic [CW-1:0] cnt1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          done,
  output logic [1:0]    phase,
  output logic [CW-1:0] steps_left
);

  state_t        state, state_nxt;
  logic [1:0]    gnt_nxt;
  logic [CW-1:0] sl_nxt;
  logic          win;

`ifdef STEP_ARB_RR_EN
  logic last;

  // On a tie, the requester that was not granted last wins.
  assign win = (req == 2'b11) ? ~last : ~req[0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                         last <= 1'b1;
    else if (state == IDLE && |req)  last <= win;
  end
`else
  assign win = ~req[0];
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sl_nxt    = steps_left;
    case (state)
      IDLE: if (|req) begin
        gnt_nxt   = win ? 2'b10 : 2'b01;
        sl_nxt    = win ? cnt1 : cnt0;
        state_nxt = (sl_nxt == '0) ? DONE : RUN;
      end
      RUN: begin
        // The decrement is guarded so steps_left can never wrap.
        if (steps_left != '0)       sl_nxt    = steps_left - 1'b1;
        if (steps_left <= CW'(1))   state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      steps_left <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      steps_left <= sl_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  phase_seq u_seq (
    .clk (clk),
    .clr (clr),
    .en  (state == RUN),
    .k   (phase[0]),
    .q   (phase)
  );

endmodule

// File: tb/tb_step_arbiter.sv
// Directed bench for step_arbiter. Expected grants, steps, phase and pulse counts are computed here.
module tb_step_arbiter;

  localparam int CW = 4;

  logic          clk, clr;
  logic [1:0]    req;
  logic [CW-1:0] cnt0, cnt1;
  logic [1:0]    gnt;
  logic          busy, done;
  logic [1:0]    phase;
  logic [CW-1:0] steps_left;

  int n_cmp = 0;
  int n_err = 0;
  int ph_m  = 0;

  step_arbiter #(.CW(CW)) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .phase      (phase),
    .steps_left (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at the negedge just after the granting edge; returns at the first IDLE negedge.
  task automatic run_job(input string tag, input logic [1:0] eg, input int n);
    int i;
    int dn;
    i  = 0;
    dn = 0;
    chk({tag, " grant"}, gnt, eg);
    while (busy && i < 40) begin
      chk({tag, " gnt"},   gnt, eg);
      chk({tag, " steps"}, steps_left, (n - i > 0) ? n - i : 0);
      chk({tag, " phase"}, phase, (ph_m + ((i < n) ? i : n)) % 4);
      chk({tag, " done"},  done, (i == n) ? 1 : 0);
      if (done) dn++;
      i++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, i, n + 1);
    chk({tag, " done pulses"}, dn, 1);
    chk({tag, " end gnt"}, gnt, 0);
    ph_m = (ph_m + n) % 4;
    chk({tag, " end phase"}, phase, ph_m);
  endtask

  initial begin
    logic [1:0] eg;
    int         en;
    clr = 1'b0; req = 2'b00; cnt0 = '0; cnt1 = '0;
    #1 clr = 1'b1;
    #2;
    chk("rst gnt", gnt, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst phase", phase, 0);
    chk("rst steps", steps_left, 0);

    // Single job from requester 0, 3 steps.
    @(negedge clk);
    clr = 1'b0; req = 2'b01; cnt0 = 4'd3;
    @(negedge clk);
    req = 2'b00;
    run_job("j3", 2'b01, 3);

    // Zero-step job from requester 1 goes straight to DONE.
    req = 2'b10; cnt1 = 4'd0;
    @(negedge clk);
    req = 2'b00;
    run_job("j0", 2'b10, 0);

    // Request dropped right after the grant; the job still completes.
    req = 2'b01; cnt0 = 4'd6;
    @(negedge clk);
    req = 2'b00;
    run_job("drop", 2'b01, 6);

    // Asynchronous clear in the middle of a job.
    req = 2'b01; cnt0 = 4'd8;
    @(negedge clk);
    req = 2'b00;
    chk("mid grant", gnt, 1);
    repeat (4) @(negedge clk);
    chk("mid steps", steps_left, 4);
    chk("mid phase", phase, ph_m);
    #2 clr = 1'b1;
    #1;
    chk("aclr gnt", gnt, 0);
    chk("aclr busy", busy, 0);
    chk("aclr done", done, 0);
    chk("aclr phase", phase, 0);
    chk("aclr steps", steps_left, 0);
    ph_m = 0;
    @(negedge clk);
    clr = 1'b0; req = 2'b10; cnt1 = 4'd1;
    @(negedge clk);
    req = 2'b00;
    run_job("post clr", 2'b10, 1);

    // Full-width count from phase 00: 15 steps end at phase 11, steps 0.
    chk("pre max phase", phase, 1);
    #2 clr = 1'b1;
    #1 ph_m = 0;
    @(negedge clk);
    clr = 1'b0; req = 2'b01; cnt0 = 4'd15;
    @(negedge clk);
    req = 2'b00;
    run_job("max", 2'b01, 15);
    chk("max final phase", phase, 3);
    chk("max final steps", steps_left, 0);

    // Held tie after a fresh clear, back-to-back with a single IDLE cycle between jobs.
    #2 clr = 1'b1;
    #1 ph_m = 0;
    @(negedge clk);
    clr = 1'b0; req = 2'b11; cnt0 = 4'd2; cnt1 = 4'd5;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
`ifdef STEP_ARB_RR_EN
      eg = (j % 2 == 1) ? 2'b10 : 2'b01;
`else
      eg = 2'b01;
`endif
      en = (eg == 2'b10) ? 5 : 2;
      run_job($sformatf("tie%0d", j), eg, en);
      @(negedge clk);
      if (j < 3) chk($sformatf("tie%0d regrant busy", j), busy, 1);
    end
    req = 2'b00;
`ifdef STEP_ARB_RR_EN
    chk("tie pair phase", phase, (7 * 2) % 4);
`else
    chk("tie fixed phase", phase, (2 * 4) % 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/step_arbiter.md
STEP_ARBITER -- requirements
Module: step_arbiter

Interface
REQ-001 SHALL have parameter CW, default 4, the step-count width in bits.
REQ-002 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req, input, 2 bits: per-requester job request, level.
REQ-005 SHALL have port cnt0, input, CW bits: step count for requester 0, sampled at grant.
REQ-006 SHALL have port cnt1, input, CW bits: step count for requester 1, sampled at grant.
REQ-007 SHALL have port gnt, output, 2 bits: one-hot grant, held for the whole job.
REQ-008 SHALL have port busy, output, 1 bit: a job is in progress (RUN or DONE).
REQ-009 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-010 SHALL have port phase, output, 2 bits: current sequencer state.
REQ-011 SHALL have port steps_left, output, CW bits: steps remaining in the current job.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE, all registered.
REQ-013 In IDLE with any req bit set: SHALL pick a winner, register the one-hot gnt, load steps_left from the winner's cnt, and go to RUN, or go to DONE if the loaded count is 0.
REQ-014 In RUN: SHALL advance phase by exactly one step per cycle and decrement steps_left by 1; when steps_left is 1 at the edge, it SHALL go to DONE with steps_left 0.
REQ-015 Phase sequence SHALL be 00->01->10->11->00, driven through the sequencer's k input with k = phase[0] and enable asserted only in RUN.
REQ-016 In DONE: done=1 and gnt held for one cycle, then IDLE with gnt=00.
REQ-017 Timing for a job of N steps: gnt visible the cycle after req is sampled; busy high for N+1 cycles; phase changes by N mod 4 across the job.
REQ-018 Phase SHALL persist across jobs; it is never reloaded per job.
REQ-019 req changes during RUN or DONE SHALL be ignored, and the job SHALL always run to completion.
REQ-020 A req still high in IDLE after DONE SHALL start a new arbitration, with no idle gap beyond the one IDLE cycle.
REQ-021 steps_left SHALL never underflow, and cnt=all-ones SHALL run 2^CW-1 steps.

Reset
REQ-022 On clr=1, regardless of clk and mid-job: state=IDLE, gnt=00, busy=0, done=0, phase=00, steps_left=0, last-grant pointer=1.
REQ-023 The first edge after clr release SHALL behave as IDLE.

Configuration
REQ-024 With STEP_ARB_RR_EN defined: round-robin arbitration, where on a tie the requester not last granted wins and the pointer updates at each grant; after reset, requester 0 wins the first tie.
REQ-025 Without STEP_ARB_RR_EN: fixed priority, where requester 0 always wins a tie and the pointer logic is absent.

Structure
REQ-026 Package step_arb_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the phase encoding constants PH0..PH3.
REQ-027 Sub-module phase_seq SHALL contain the 2-bit k-driven sequencer with clk, clr and enable, instantiated once.

Verification
REQ-028 clr, then req=01 with cnt0=3 -> gnt=01 the next cycle; phase 00->01->10->11 over 3 cycles; done pulses once; busy high 4 cycles.
REQ-029 req=11 held with cnt0=2, cnt1=5, macro on -> grant order 0,1,0,1; phase advances 7 per pair of jobs. Macro off -> requester 0 granted every time.
REQ-030 req=10 with cnt1=0 -> gnt=10, DONE next cycle, done pulses, phase unchanged.
REQ-031 clr asserted mid-RUN with steps_left=4 -> all outputs return to reset values immediately, without waiting for clk.
REQ-032 req dropped to 00 one cycle after grant with cnt0=6 -> job completes all 6 steps and done still pulses.
REQ-033 CW=4, cnt0=15 -> 15 phase steps, final phase 11 from start 00, steps_left ends at 0 with no wrap.
